m65c02a_map_ctx_loader: RTL

//  Context-switch sequencer for the M65C02A MMU MAP RAM. On Start it copies a contiguous

---
 rtl/m65c02a_map_ctx_loader_if.sv | 47 ++++
 rtl/m65c02a_map_ctx_loader.sv | 91 +++++++++
 2 files changed

// File: rtl/m65c02a_map_ctx_loader_if.sv
// m65c02a_map_ctx_loader_if
//   Bundles the MMU MAP byte-write port, the context-save RAM read port and the
//   control handshake of the MAP context loader.
//   master : the loader (drives Src_*, MAP_*, Busy, Done)
//   slave  : the surrounding system (drives Rdy, Start, Abort, Ctx, CPU_Req, Src_DI)
//   rdy      M65C02A microcycle ready; a MAP write commits only when high
//   start    request a context load
//   abort    cancel a load in progress
//   ctx      context number, latched on an accepted start
//   cpu_req  CPU owns the MMU/MAP port this cycle
//   src_re   context RAM read strobe
//   src_a    context RAM byte address {ctx, byte index}
//   src_di   context RAM data, valid the cycle after src_re
//   map_sel  MMU Sel_MAP
//   map_we   MMU WE
//   map_a    MMU VA[5:0]
//   map_do   MMU MMU_DI
//   busy     load in progress
//   done     one-cycle pulse on successful completion
interface m65c02a_map_ctx_loader_if #(
  parameter int p_ctx_w = 4
);
  logic               rdy;
  logic               start;
  logic               abort;
  logic [p_ctx_w-1:0] ctx;
  logic               cpu_req;
  logic               src_re;
  logic [p_ctx_w+4:0] src_a;
  logic [7:0]         src_di;
  logic               map_sel;
  logic               map_we;
  logic [5:0]         map_a;
  logic [7:0]         map_do;
  logic               busy;
  logic               done;

  modport master (
    input  rdy, start, abort, ctx, cpu_req, src_di,
    output src_re, src_a, map_sel, map_we, map_a, map_do, busy, done
  );

  modport slave (
    output rdy, start, abort, ctx, cpu_req, src_di,
    input  src_re, src_a, map_sel, map_we, map_a, map_do, busy, done
  );
endinterface

// File: rtl/m65c02a_map_ctx_loader.sv
// m65c02a_map_ctx_loader
//   Context-switch sequencer for the M65C02A MMU MAP RAM. On start it copies
//   p_count bytes from the context-save RAM (address {ctx, byte index}) into
//   the MAP byte write port, starting at MAP byte p_base and ascending with
//   6-bit wrap. The CPU always has priority on the MAP port.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    loader side of m65c02a_map_ctx_loader_if (see interface header)
module m65c02a_map_ctx_loader #(
  parameter logic [5:0] p_base  = 6'd32,
  parameter int         p_count = 32,
  parameter int         p_ctx_w = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  m65c02a_map_ctx_loader_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    DONE
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(p_count - 1);

  state_t             state;
  logic [5:0]         cnt;
  logic [7:0]         data_buf;
  logic [p_ctx_w-1:0] ctx_r;

  logic write_en;
  logic commit;

  // The CPU always wins the MAP port; a write only lands when the microcycle is ready.
  assign write_en = (state == WRITE) && !bus.cpu_req;
  assign commit   = write_en && bus.rdy;

  // Sequencer: one byte takes READ -> CAPT -> WRITE; WRITE holds until committed.
  // Abort overrides everything except reset, but only outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data_buf <= '0;
      ctx_r    <= '0;
    end else if (bus.abort && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            ctx_r <= bus.ctx;
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          data_buf <= bus.src_di;
          state    <= WRITE;
        end
        WRITE: begin
          if (commit) begin
            if (cnt == LAST_CNT) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 6'd1;
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of state and registers, so reset forces them all low.
  assign bus.src_re  = (state == READ);
  assign bus.src_a   = (state == READ) ? {ctx_r, cnt[4:0]} : '0;
  assign bus.map_sel = write_en;
  assign bus.map_we  = write_en;
  assign bus.map_a   = (state == WRITE) ? (p_base + cnt) : 6'd0;
  assign bus.map_do  = write_en ? data_buf : 8'd0;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

endmodule
